// File: rtl/rcvr_pkg.sv
// rtl/rcvr_pkg.sv - shared constants and FSM state type for the receiver arbiter
package rcvr_pkg;
    localparam int FRAME_W = 8;
    localparam logic [FRAME_W-1:0] MATCH = 8'hA5;

    typedef enum logic {
        SCAN = 1'b0,
        READ = 1'b1
    } state_t;
endpackage

// File: rtl/rcvr_arbiter_if.sv
// rtl/rcvr_arbiter_if.sv - receiver-bank, consumer and error signals of the arbiter
interface rcvr_arbiter_if #(
    parameter int N = 4
) ();
    import rcvr_pkg::*;

    localparam int CW = $clog2(N);

    logic [N-1:0]         ch_ready;
    logic [N-1:0]         ch_overrun;
    logic [FRAME_W*N-1:0] ch_data;
    logic [N-1:0]         ch_reading;
    logic                 out_valid;
    logic                 out_ready;
    logic [FRAME_W-1:0]   out_data;
    logic [CW-1:0]        out_chan;
    logic [N-1:0]         err;
    logic [N-1:0]         err_clear;
    logic                 fifo_full;

    modport master (
        input  ch_ready, ch_overrun, ch_data, out_ready, err_clear,
        output ch_reading, out_valid, out_data, out_chan, err, fifo_full
    );

    modport slave (
        output ch_ready, ch_overrun, ch_data, out_ready, err_clear,
        input  ch_reading, out_valid, out_data, out_chan, err, fifo_full
    );
endinterface

// File: rtl/rcvr_fifo.sv
// rtl/rcvr_fifo.sv - synchronous FIFO holding {channel, byte} entries for the consumer
module rcvr_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    // Head comes straight from storage registers, so o_data never depends on i_pop.
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset_n && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/rcvr_arbiter.sv
// rtl/rcvr_arbiter.sv - round-robin read controller for a bank of serial frame receivers
module rcvr_arbiter
    import rcvr_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    rcvr_arbiter_if.master bus
);
    localparam int CW = $clog2(N);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_grant;
    logic [CW-1:0]       w_grant_nxt;
    logic [CW-1:0]       r_ptr;
    logic [CW-1:0]       w_ptr_nxt;
    logic [N-1:0]        r_reading;
    logic [N-1:0]        w_reading_nxt;
    logic [N-1:0]        r_err;
    logic [N-1:0]        w_req;
    logic [CW:0]         w_pick;
    logic                w_push;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [FRAME_W+CW-1:0] w_push_data;
    logic [FRAME_W+CW-1:0] w_head;

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [CW:0] rr_pick(input logic [N-1:0] req, input logic [CW-1:0] ptr);
        logic [CW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                res = {1'b1, CW'(idx)};
            end
        end
        return res;
    endfunction

    assign w_req       = bus.ch_ready & {N{~w_fifo_full}};
    assign w_pick      = rr_pick(w_req, r_ptr);
    assign w_push_data = {r_grant, bus.ch_data[r_grant*FRAME_W +: FRAME_W]};

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_ptr_nxt     = r_ptr;
        w_reading_nxt = '0;
        w_push        = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_pick[CW]) begin
                    w_grant_nxt   = w_pick[CW-1:0];
                    w_reading_nxt = {{(N-1){1'b0}}, 1'b1} << w_pick[CW-1:0];
                    w_state_nxt   = READ;
                end
            end
            READ: begin
                w_push      = 1'b1;
                w_ptr_nxt   = (r_grant == CW'(N - 1)) ? '0 : r_grant + 1'b1;
                w_state_nxt = SCAN;
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= SCAN;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_reading <= '0;
            r_err     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_reading <= w_reading_nxt;
            // A fresh overrun outranks a clear in the same cycle.
            r_err     <= (r_err & ~bus.err_clear) | bus.ch_overrun;
        end
    end

    rcvr_fifo #(
        .W     (FRAME_W + CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (bus.out_ready),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.ch_reading = r_reading;
    assign bus.out_valid  = ~w_fifo_empty;
    assign bus.out_data   = w_head[FRAME_W-1:0];
    assign bus.out_chan   = w_head[FRAME_W+CW-1:FRAME_W];
    assign bus.err        = r_err;
    assign bus.fifo_full  = w_fifo_full;
endmodule

// File: tb/tb_rcvr_arbiter.sv
// tb/tb_rcvr_arbiter.sv - directed scoreboard bench for rcvr_arbiter
module tb_rcvr_arbiter;
    import rcvr_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic [CW+7:0] sb_q [$];
    logic [N-1:0]  prev_reading = '0;

    rcvr_arbiter_if #(.N(N)) bus ();

    rcvr_arbiter #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Receivers drop ready at the edge that ends their reading cycle.
    task automatic tick();
        logic [N-1:0] rd;
        rd = bus.ch_reading;
        @(posedge clock);
        #1;
        bus.ch_ready = bus.ch_ready & ~rd;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 40 && (sb_q.size() != 0 || bus.out_valid); n++) tick();
        check(tag, 32'(sb_q.size()), 0);
        check({tag, "_valid"}, 32'(bus.out_valid), 0);
    endtask

    always @(negedge clock) begin
        logic [CW+7:0] expe;
        check("reading_onehot0", 32'($onehot0(bus.ch_reading)), 1);
        check("reading_consecutive", 32'(|(prev_reading & bus.ch_reading)), 0);
        prev_reading = bus.ch_reading;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            check("sb_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                expe = sb_q.pop_front();
                check("sb_entry", 32'({bus.out_chan, bus.out_data}), 32'(expe));
            end
        end
    end

    initial begin
        bus.ch_ready   = '0;
        bus.ch_overrun = '0;
        bus.ch_data    = '0;
        bus.out_ready  = 1'b0;
        bus.err_clear  = '0;
        repeat (3) tick();
        check("rst_reading", 32'(bus.ch_reading), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_full", 32'(bus.fifo_full), 0);
        reset_n = 1'b1;
        tick();

        // single channel, latency
        bus.out_ready        = 1'b1;
        bus.ch_data[23:16]   = 8'h3C;
        bus.ch_ready[2]      = 1'b1;
        sb_q.push_back({2'd2, 8'h3C});
        tick();
        check("sc_t1_reading", 32'(bus.ch_reading), 32'h4);
        check("sc_t1_valid", 32'(bus.out_valid), 0);
        tick();
        check("sc_t2_reading", 32'(bus.ch_reading), 0);
        check("sc_t2_valid", 32'(bus.out_valid), 1);
        check("sc_t2_data", 32'(bus.out_data), 32'h3C);
        check("sc_t2_chan", 32'(bus.out_chan), 2);
        tick();
        check("sc_t3_valid", 32'(bus.out_valid), 0);

        // channel 3 alone so the pointer wraps to 0
        bus.ch_data[31:24] = 8'h77;
        bus.ch_ready[3]    = 1'b1;
        sb_q.push_back({2'd3, 8'h77});
        repeat (4) tick();

        // fairness from pointer 0
        for (int i = 0; i < N; i++) bus.ch_data[8*i +: 8] = 8'(8'h10 + i);
        for (int k = 0; k < N; k++) sb_q.push_back({CW'(k), 8'(8'h10 + k)});
        bus.ch_ready = '1;
        for (int k = 0; k < N; k++) begin
            tick();
            check("fair0_grant", 32'(bus.ch_reading), 32'(1 << k));
            tick();
            check("fair0_gap", 32'(bus.ch_reading), 0);
        end
        drain("fair0_drain");

        // channel 1 alone moves the pointer to 2
        bus.ch_data[15:8] = 8'h21;
        bus.ch_ready[1]   = 1'b1;
        sb_q.push_back({2'd1, 8'h21});
        tick();
        check("ptr2_grant", 32'(bus.ch_reading), 32'h2);
        repeat (3) tick();

        // fairness from pointer 2
        for (int i = 0; i < N; i++) bus.ch_data[8*i +: 8] = 8'(8'h30 + i);
        for (int k = 0; k < N; k++) sb_q.push_back({CW'((2 + k) % N), 8'(8'h30 + (2 + k) % N)});
        bus.ch_ready = '1;
        for (int k = 0; k < N; k++) begin
            tick();
            check("fair2_grant", 32'(bus.ch_reading), 32'(1 << ((2 + k) % N)));
            tick();
            check("fair2_gap", 32'(bus.ch_reading), 0);
        end
        drain("fair2_drain");

        // full FIFO back-pressure, pointer at 2
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) bus.ch_data[8*i +: 8] = 8'(8'hA0 + i);
        for (int k = 0; k < N; k++) sb_q.push_back({CW'((2 + k) % N), 8'(8'hA0 + (2 + k) % N)});
        bus.ch_ready = '1;
        repeat (8) tick();
        check("full_flag", 32'(bus.fifo_full), 1);
        check("full_head", 32'({bus.out_chan, bus.out_data}), 32'({2'd2, 8'hA2}));
        bus.ch_data[15:8] = 8'hB1;
        bus.ch_ready[1]   = 1'b1;
        sb_q.push_back({2'd1, 8'hB1});
        repeat (3) begin
            tick();
            check("full_no_grant", 32'(bus.ch_reading), 0);
        end
        check("full_still", 32'(bus.fifo_full), 1);
        bus.out_ready = 1'b1;
        drain("full_drain");
        check("full_ch1_read", 32'(bus.ch_ready[1]), 0);

        // sticky overrun flags
        bus.ch_overrun[3] = 1'b1;
        tick();
        bus.ch_overrun[3] = 1'b0;
        check("err_set", 32'(bus.err), 32'h8);
        tick();
        check("err_sticky", 32'(bus.err), 32'h8);
        bus.ch_overrun[3] = 1'b1;
        bus.err_clear[3]  = 1'b1;
        tick();
        bus.ch_overrun[3] = 1'b0;
        check("err_set_wins", 32'(bus.err), 32'h8);
        tick();
        check("err_clear_only", 32'(bus.err), 0);
        bus.err_clear[3] = 1'b0;

        // reset in the middle of READ
        bus.ch_overrun[0] = 1'b1;
        tick();
        bus.ch_overrun[0] = 1'b0;
        check("pre_rst_err", 32'(bus.err), 32'h1);
        bus.ch_data[15:8] = 8'h66;
        bus.ch_ready[1]   = 1'b1;
        tick();
        check("pre_rst_read", 32'(bus.ch_reading), 32'h2);
        reset_n = 1'b0;
        tick();
        check("rr_reading", 32'(bus.ch_reading), 0);
        check("rr_valid", 32'(bus.out_valid), 0);
        check("rr_err", 32'(bus.err), 0);
        reset_n = 1'b1;
        bus.ch_data[7:0]   = 8'h44;
        bus.ch_data[31:24] = 8'h33;
        bus.ch_ready[0]    = 1'b1;
        bus.ch_ready[3]    = 1'b1;
        sb_q.push_back({2'd0, 8'h44});
        sb_q.push_back({2'd3, 8'h33});
        tick();
        check("rr_ptr0", 32'(bus.ch_reading), 32'h1);
        drain("rr_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rcvr_arbiter.md
# rcvr_arbiter

Round-robin read controller for a bank of N serial frame receivers. It watches each receiver's `ready`/`overrun` flags and issues single-cycle `reading` pulses to one receiver at a time. Each captured byte and its channel number go into a small output FIFO, and the block keeps sticky per-channel overrun error flags. It sits between the receiver bank and the downstream byte consumer, which reads through a valid/ready port.

## Interface
Parameters:
- `N`, 4: number of receiver channels, 2..8.
- `DEPTH`, 4: output FIFO entries, power of two, ≥2.
- `CW`, $clog2(N): channel index width (derived).

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `ch_ready`  in  N  per-channel receiver `ready`.
- `ch_overrun`  in  N  per-channel receiver `overrun`.
- `ch_data`  in  8*N  receiver `data_out` buses; channel i occupies bits [8i+7:8i].
- `ch_reading`  out  N  registered one-hot `reading` pulses to the receivers.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head entry when high with `out_valid`.
- `out_data`  out  8  head byte.
- `out_chan`  out  CW  channel index of the head byte.
- `err`  out  N  sticky overrun flags.
- `err_clear`  in  N  per-bit clear mask for `err`.
- `fifo_full`  out  1  status only.

## Operation
- Reset (`reset_n`=0 at an edge): FSM goes to SCAN, `ch_reading`=0, FIFO empty (`out_valid`=0), `err`=0, round-robin pointer=0. `out_data`/`out_chan` are don't-care while `out_valid`=0.
- SCAN state:
  - Requests are `ch_ready & {N{~fifo_full}}`.
  - If any request is set, grant the first requester at or after the pointer, wrapping modulo N.
  - Register the grant index and the one-hot `ch_reading`, then go to READ.
  - If no request is set, stay in SCAN.
- READ state:
  - `ch_reading[grant]`=1 for exactly this cycle.
  - Push {grant, `ch_data[grant]`} into the FIFO at the end of the cycle; receiver data is stable while its `ready` is high.
  - Set pointer = grant+1 (wrapping modulo N) and return to SCAN.
  - The receiver drops `ready` at this same edge, so no extra settle state is needed.
- Back-to-back frame: if the receiver completes a new frame in the same cycle as `reading`, its `ready` stays 1. The next SCAN treats this as a fresh request, and that is the required behaviour.
- FIFO full: no grants are made. Receivers keep `ready` and will raise `overrun` on their next frame, which is the intended back-pressure outcome.
- Simultaneous push and pop on a full FIFO cannot occur because no grant is made when full. Push and pop together on a non-empty, non-full FIFO leave the count unchanged.
- `err[i]`:
  - Set whenever `ch_overrun[i]`=1 is sampled, every cycle including READ.
  - Cleared when `err_clear[i]`=1.
  - If set and clear happen in the same cycle, set wins.
- Reset in the middle of READ: the pending push is discarded and `ch_reading` is 0 in the next cycle.

## Timing
- `ch_ready[i]` sampled high in SCAN in cycle t (FIFO not full, highest-priority requester):
  - `ch_reading[i]`=1 in cycle t+1.
  - Entry is written at the end of t+1.
  - `out_valid`=1 in cycle t+2.
- Sustained throughput is one byte per 2 cycles. The minimum frame period is 16 cycles, so N ≤ 8 never starves for bandwidth.
- `ch_reading` is never multi-hot and never high for 2 consecutive cycles.
- Pop happens on an edge with `out_valid` & `out_ready`. `out_data`/`out_chan` are the registered head entry with no combinational path from `out_ready`.

## Structure
- Shared package `rcvr_pkg`: `FRAME_W`=8, `MATCH`=8'hA5, and the FSM state enum {SCAN, READ}.
- Sub-module `rcvr_fifo`: synchronous FIFO with parameterized width (8+CW) and depth.
  - Exposes full/empty and push/pop.
  - Uses a count of width $clog2(DEPTH)+1 and pointers that wrap modulo DEPTH.
- Round-robin priority selection is kept inline as a function in the arbiter.

## Test plan
- Single channel: channel 2 raises `ready` with data 8'h3C, `out_ready`=1. Expect `ch_reading`=4'b0100 for exactly one cycle, then `out_valid` with `out_data`=8'h3C and `out_chan`=2 two cycles after `ready`.
- Fairness: all 4 channels ready at once with data 8'h10..8'h13, pointer at 0. Expect output order chan 0,1,2,3 at one grant per 2 cycles. A repeat with the pointer at 2 gives order 2,3,0,1.
- Full FIFO:
  - With `out_ready`=0, issue 5 requests and expect 4 entries then `fifo_full`=1.
  - Channel 1's `ready` stays high with no `ch_reading` pulse.
  - Raising `out_ready` drains the FIFO in order and then grants channel 1.
- Overrun:
  - Pulse `ch_overrun[3]` for one cycle and expect `err[3]`=1 to persist.
  - Assert `err_clear[3]` in the same cycle as another `ch_overrun[3]` and expect `err[3]` to stay 1.
  - Assert `err_clear[3]` alone and expect `err[3]`=0.
- Reset during READ: drive `reset_n`=0 in the READ cycle. Next cycle expect `ch_reading`=0, `out_valid`=0, `err`=0, pointer 0.
